// File: rtl/shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier_if
//   Handshake and data bundle for the sequential shift-add multiplier.
//   The master issues requests; the slave (the multiplier) reports status
//   and the result.
//
// Parameters
//   WIDTH    operand width; product is 2*WIDTH bits
//
// Signals
//   start    master -> slave  request, sampled only while the slave is idle
//                             or in its done cycle
//   a        master -> slave  multiplicand (captured on accepted start)
//   b        master -> slave  multiplier   (captured on accepted start)
//   busy     slave -> master  high while the iteration loop runs
//   done     slave -> master  one-cycle pulse when product becomes valid
//   product  slave -> master  result, held until the next completion or reset
// ---------------------------------------------------------------------------
interface shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                   start;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// shift_add_multiplier
//   Sequential unsigned WIDTH x WIDTH multiplier. One ripple-carry adder of
//   WIDTH full adders is reused each clock; the accumulator and multiplier
//   registers form one 2*WIDTH+1-bit shift register (carry on top).
//
// Parameters
//   WIDTH    operand width (>= 2)
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      synchronous active-high reset; aborts any running operation
//   bus      shift_add_multiplier_if.slave (start/a/b in, busy/done/product out)
//
// Build option
//   SHIFT_ADD_MULT_EARLY_TERM_EN  when defined, the loop stops as soon as the
//   remaining unconsumed multiplier bits are all zero and the outstanding
//   shifts are applied in one step. Results are identical; only latency
//   changes. When undefined, every operation takes exactly WIDTH iterations.
// ---------------------------------------------------------------------------
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [WIDTH-1:0]     mplr_reg;
  logic [WIDTH-1:0]     acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   product_reg;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_next;
  logic [WIDTH-1:0]     mplr_next;
  logic [2*WIDTH-1:0]   shifted;
  logic [2*WIDTH-1:0]   product_next;
  logic                 last_iter;

  // Partial product for this step: multiplicand gated by the current
  // multiplier LSB.
  assign addend = mplr_reg[0] ? mcand_reg : '0;

  // Ripple-carry chain; each stage keeps its own carry-out so the chain is
  // not a self-referencing vector.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      logic c_in;
      logic c_out;
      if (gi == 0) begin : g_first
        assign c_in = 1'b0;
      end else begin : g_rest
        assign c_in = g_fa[gi-1].c_out;
      end
      assign sum[gi] = acc_reg[gi] ^ addend[gi] ^ c_in;
      assign c_out   = (acc_reg[gi] & addend[gi]) | (c_in & (acc_reg[gi] ^ addend[gi]));
    end
  endgenerate

  assign sum[WIDTH] = g_fa[WIDTH-1].c_out;

  // {sum, mplr} >> 1: carry drops into the accumulator MSB and the sum LSB
  // becomes the next settled product bit at the top of the multiplier reg.
  assign acc_next  = sum[WIDTH:1];
  assign mplr_next = {sum[0], mplr_reg[WIDTH-1:1]};
  assign shifted   = {acc_next, mplr_next};

`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
  // After iteration cnt, the low WIDTH-1-cnt bits of mplr_next are still
  // original multiplier bits. If they are all zero, the remaining steps would
  // only shift, so apply that shift directly.
  logic [WIDTH-1:0] rem_mask;
  logic [CNT_W-1:0] shamt;

  assign rem_mask     = {WIDTH{1'b1}} >> (cnt_reg + CNT_W'(1));
  assign last_iter    = ((mplr_next & rem_mask) == '0);
  assign shamt        = CNT_W'(WIDTH - 1) - cnt_reg;
  assign product_next = shifted >> shamt;
`else
  assign last_iter    = (cnt_reg == CNT_W'(WIDTH - 1));
  assign product_next = shifted;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mcand_reg   <= '0;
      mplr_reg    <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // The done cycle also accepts a new request (back-to-back).
          if (bus.start) begin
            mcand_reg <= bus.a;
            mplr_reg  <= bus.b;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          acc_reg  <= acc_next;
          mplr_reg <= mplr_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            product_reg <= product_next;
            state_reg   <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy    = (state_reg == RUN);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_shift_add_multiplier
//   Self-checking bench: a WIDTH=4 instance for directed scenarios and a
//   WIDTH=8 instance for randomized operand pairs. Expected products come
//   from plain integer multiplication; expected iteration counts come from
//   the operand value (fixed WIDTH, or position of the highest set bit of b
//   when the early-termination build is selected).
// ---------------------------------------------------------------------------
module tb_shift_add_multiplier;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shift_add_multiplier_if #(.WIDTH(4)) if4 ();
  shift_add_multiplier_if #(.WIDTH(8)) if8 ();

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference latency: number of busy cycles for multiplier value bv.
  function automatic int exp_iters(input logic [7:0] bv, input int w);
    int n;
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
    n = 1;
    for (int i = 0; i < w; i++)
      if (bv[i]) n = i + 1;
`else
    n = w;
`endif
    return n;
  endfunction

  // One operation on the 4-bit instance; returns what was observed.
  task automatic op4(input logic [3:0] ai, input logic [3:0] bi,
                     output logic [7:0] p, output int iters,
                     output bit seen, output bit overlap);
    p = '0; iters = 0; seen = 0; overlap = 0;
    @(negedge clk);
    if4.a = ai; if4.b = bi; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.a = 4'($urandom); if4.b = 4'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (if4.busy && if4.done) overlap = 1;
      if (if4.done) begin
        seen = 1; p = if4.product;
      end else begin
        if (if4.busy) iters++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic op8(input logic [7:0] ai, input logic [7:0] bi,
                     output logic [15:0] p, output int iters,
                     output bit seen, output bit overlap);
    p = '0; iters = 0; seen = 0; overlap = 0;
    @(negedge clk);
    if8.a = ai; if8.b = bi; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (if8.busy && if8.done) overlap = 1;
      if (if8.done) begin
        seen = 1; p = if8.product;
      end else begin
        if (if8.busy) iters++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.product !== 8'd0) begin
      errors++;
      $display("FAIL reset4 busy=%b done=%b product=%0d required 0/0/0", if4.busy, if4.done, if4.product);
    end
    checks++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b0 || if8.product !== 16'd0) begin
      errors++;
      $display("FAIL reset8 busy=%b done=%b product=%0d required 0/0/0", if8.busy, if8.done, if8.product);
    end
    rst = 1'b0;
    $display("reset: done");
  endtask

  // Directed 4-bit case: product, busy length, no busy/done overlap.
  task automatic run_case4(input string name, input logic [3:0] ai, input logic [3:0] bi);
    logic [7:0] p; int it; bit seen; bit ov;
    logic [7:0] exp_p;
    exp_p = 8'(int'(ai) * int'(bi));
    op4(ai, bi, p, it, seen, ov);
    $display("txn %s a=%0d b=%0d product=%0d iters=%0d", name, ai, bi, p, it);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s_timeout done not seen, required done pulse", name);
    end
    checks++;
    if (p !== exp_p) begin
      errors++; $display("FAIL %s_product got %0d required %0d", name, p, exp_p);
    end
    checks++;
    if (it !== exp_iters({4'd0, bi}, 4)) begin
      errors++; $display("FAIL %s_iters got %0d required %0d", name, it, exp_iters({4'd0, bi}, 4));
    end
    checks++;
    if (ov !== 1'b0) begin
      errors++; $display("FAIL %s_overlap busy and done high together, got 1 required 0", name);
    end
  endtask

  task automatic test_basic();
    run_case4("basic", 4'd13, 4'd11);
    // Done must be a single-cycle pulse and product must hold.
    @(posedge clk); #1;
    checks++;
    if (if4.done !== 1'b0) begin
      errors++; $display("FAIL basic_pulse done=%b required 0", if4.done);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (if4.product !== 8'd143) begin
      errors++; $display("FAIL basic_hold product=%0d required 143", if4.product);
    end
  endtask

  task automatic test_corners();
    run_case4("max", 4'd15, 4'd15);
    run_case4("a_zero", 4'd0, 4'd9);
    run_case4("b_zero", 4'd9, 4'd0);
  endtask

  task automatic test_early_term();
    run_case4("et_b1", 4'd7, 4'd1);
    run_case4("et_b8", 4'd7, 4'd8);
    run_case4("et_b0", 4'd7, 4'd0);
  endtask

  // start held high with other operands during RUN must be ignored; in the
  // done cycle it must be accepted without an idle cycle.
  task automatic test_back_to_back();
    int  it; bit seen;
    @(negedge clk);
    if4.a = 4'd5; if4.b = 4'd6; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.a = 4'd1; if4.b = 4'd1;
    it = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (if4.done) seen = 1;
      else begin
        if (if4.busy) it++;
        @(posedge clk); #1;
      end
    end
    $display("txn b2b_first a=5 b=6 product=%0d iters=%0d", if4.product, it);
    checks++;
    if (!seen || if4.product !== 8'd30) begin
      errors++; $display("FAIL b2b_first seen=%b product=%0d required 30", seen, if4.product);
    end
    checks++;
    if (it !== exp_iters(8'd6, 4)) begin
      errors++; $display("FAIL b2b_first_iters got %0d required %0d", it, exp_iters(8'd6, 4));
    end
    @(posedge clk); #1;
    if4.start = 1'b0;
    checks++;
    if (if4.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept busy=%b required 1", if4.busy);
    end
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (if4.done) seen = 1;
      else begin @(posedge clk); #1; end
    end
    $display("txn b2b_second a=1 b=1 product=%0d", if4.product);
    checks++;
    if (!seen || if4.product !== 8'd1) begin
      errors++; $display("FAIL b2b_second seen=%b product=%0d required 1", seen, if4.product);
    end
  endtask

  // Reset sampled at the second RUN edge aborts the operation.
  task automatic test_reset_abort();
    bit saw_done; bit saw_busy;
    @(negedge clk);
    if4.a = 4'd13; if4.b = 4'd11; if4.start = 1'b1;
    @(posedge clk); #1;            // E0: accepted
    if4.start = 1'b0;
    @(posedge clk); #1;            // E1: first iteration
    rst = 1'b1;
    @(posedge clk); #1;            // E2: reset sampled
    rst = 1'b0;
    checks++;
    if (if4.busy !== 1'b0 || if4.done !== 1'b0 || if4.product !== 8'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b product=%0d required 0/0/0", if4.busy, if4.done, if4.product);
    end
    saw_done = 0; saw_busy = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if4.done) saw_done = 1;
      if (if4.busy) saw_busy = 1;
    end
    $display("txn abort done_after=%b busy_after=%b", saw_done, saw_busy);
    checks++;
    if (saw_done !== 1'b0 || saw_busy !== 1'b0) begin
      errors++; $display("FAIL abort_quiet done=%b busy=%b required 0/0", saw_done, saw_busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] p; int it; bit seen; bit ov;
    logic [7:0]  ra; logic [7:0] rb;
    int accepted; int dones;
    accepted = 0; dones = 0;
    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom);
      // Mix in narrow multipliers so short early-termination runs occur.
      rb = (n % 4 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      op8(ra, rb, p, it, seen, ov);
      accepted++;
      if (seen) dones++;
      $display("txn rand%0d a=%0d b=%0d product=%0d iters=%0d", n, ra, rb, p, it);
      checks++;
      if (p !== 16'(int'(ra) * int'(rb))) begin
        errors++; $display("FAIL rand_product a=%0d b=%0d got %0d required %0d", ra, rb, p, int'(ra) * int'(rb));
      end
      checks++;
      if (it !== exp_iters(rb, 8) || ov !== 1'b0) begin
        errors++; $display("FAIL rand_iters b=%0d got %0d overlap=%b required %0d overlap=0", rb, it, ov, exp_iters(rb, 8));
      end
    end
    checks++;
    if (dones !== accepted) begin
      errors++; $display("FAIL rand_done_count got %0d required %0d", dones, accepted);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_abort();
    test_early_term();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
